// File: rtl/data_mem_pkg.sv
// Shared constants and payload types for the data-side memory controller.
package data_mem_pkg;

  localparam int unsigned DATA_W = 32;

  // Address region decoded from dataAddr[31:28]
  localparam logic [3:0] REGION_RAM = 4'h0;
  localparam logic [3:0] REGION_REG = 4'h1;

  // Register offsets decoded from dataAddr[3:2]
  localparam logic [1:0] GPO    = 2'd0;
  localparam logic [1:0] TCTRL  = 2'd1;
  localparam logic [1:0] TLOAD  = 2'd2;
  localparam logic [1:0] TCOUNT = 2'd3;

  // TCTRL bit indices
  localparam int unsigned EN     = 0;
  localparam int unsigned RELOAD = 1;
  localparam int unsigned PEND   = 2;

  // Register-block write port, already qualified by region decode
  typedef struct packed {
    logic              we;
    logic [1:0]        off;
    logic [DATA_W-1:0] wdata;
  } reg_wr_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core-to-controller data bus: store enable, address, store data, load data.
interface data_mem_ctrl_if;
  import data_mem_pkg::*;

  logic              dataWe;
  logic [DATA_W-1:0] dataAddr;
  logic [DATA_W-1:0] datawData;
  logic [DATA_W-1:0] rData;

  modport master (output dataWe, output dataAddr, output datawData, input rData);
  modport slave  (input dataWe, input dataAddr, input datawData, output rData);

endinterface

// File: rtl/timer_unit.sv
// Down-counting timer with one-shot/auto-reload modes and a W1C pending flag.
module timer_unit
  import data_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  reg_wr_t           i_wr,
  output logic [DATA_W-1:0] o_tctrl,
  output logic [DATA_W-1:0] o_tload,
  output logic [DATA_W-1:0] o_count,
  output logic              o_irq
);

  logic              r_en, r_reload, r_pend;
  logic [DATA_W-1:0] r_tload, r_count;

  logic              w_en_n, w_reload_n, w_pend_n;
  logic [DATA_W-1:0] w_tload_n, w_count_n;
  logic              w_ctrl_wr, w_load_wr, w_expire, w_dec;

  assign w_ctrl_wr = i_wr.we && (i_wr.off == TCTRL);
  assign w_load_wr = i_wr.we && (i_wr.off == TLOAD);
  assign w_expire  = r_en && (r_count == '0);
  assign w_dec     = r_en && (r_count != '0);

  // Next-state: expiry sets PEND over a W1C, TLOAD writes win over counting
  always_comb begin
    w_en_n     = r_en;
    w_reload_n = r_reload;
    w_pend_n   = r_pend;
    w_tload_n  = r_tload;
    w_count_n  = r_count;

    if (w_expire && !r_reload) w_en_n = 1'b0;
    if (w_ctrl_wr) begin
      w_en_n     = i_wr.wdata[EN];
      w_reload_n = i_wr.wdata[RELOAD];
      if (i_wr.wdata[PEND]) w_pend_n = 1'b0;
    end
    if (w_expire) w_pend_n = 1'b1;

    if (w_expire)   w_count_n = r_reload ? r_tload : '0;
    else if (w_dec) w_count_n = r_count - DATA_W'(1);

    if (w_load_wr) begin
      w_tload_n = i_wr.wdata;
      w_count_n = i_wr.wdata;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en     <= 1'b0;
      r_reload <= 1'b0;
      r_pend   <= 1'b0;
      r_tload  <= '0;
      r_count  <= '0;
    end else begin
      r_en     <= w_en_n;
      r_reload <= w_reload_n;
      r_pend   <= w_pend_n;
      r_tload  <= w_tload_n;
      r_count  <= w_count_n;
    end
  end

  assign o_tctrl = {29'b0, r_pend, r_reload, r_en};
  assign o_tload = r_tload;
  assign o_count = r_count;
  assign o_irq   = r_pend;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: word RAM plus GPO/timer register block.
// Optional timer enabled by defining DATA_MEM_TIMER_EN.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned GPO_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  data_mem_ctrl_if.slave   bus,
  output logic [GPO_W-1:0] gpo,
  output logic             timerIrq
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [GPO_W-1:0]  r_gpo;

  logic [3:0]        w_region;
  logic [1:0]        w_off;
  logic [AW-1:0]     w_idx;
  logic              w_ram_we;
  reg_wr_t           w_reg_wr;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_tctrl, w_tload, w_count;
  logic              w_irq;
  logic              w_unused;

  assign w_region = bus.dataAddr[31:28];
  assign w_off    = bus.dataAddr[3:2];
  assign w_idx    = bus.dataAddr[AW+1:2];
  assign w_ram_we = bus.dataWe && (w_region == REGION_RAM);

  assign w_reg_wr.we    = bus.dataWe && (w_region == REGION_REG);
  assign w_reg_wr.off   = w_off;
  assign w_reg_wr.wdata = bus.datawData;

  // Synchronous RAM write, no reset so contents survive reset
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_idx] <= bus.datawData;
  end

  // General-purpose output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   r_gpo <= '0;
    else if (w_reg_wr.we && w_reg_wr.off == GPO) r_gpo <= w_reg_wr.wdata[GPO_W-1:0];
  end

`ifdef DATA_MEM_TIMER_EN
  timer_unit u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (w_reg_wr),
    .o_tctrl (w_tctrl),
    .o_tload (w_tload),
    .o_count (w_count),
    .o_irq   (w_irq)
  );
`else
  assign w_tctrl = '0;
  assign w_tload = '0;
  assign w_count = '0;
  assign w_irq   = 1'b0;
`endif

  // Zero-latency load mux; unmapped regions read zero
  always_comb begin
    w_rdata = '0;
    if (w_region == REGION_RAM) begin
      w_rdata = r_mem[w_idx];
    end else if (w_region == REGION_REG) begin
      case (w_off)
        GPO:     w_rdata = DATA_W'(r_gpo);
        TCTRL:   w_rdata = w_tctrl;
        TLOAD:   w_rdata = w_tload;
        TCOUNT:  w_rdata = w_count;
        default: w_rdata = '0;
      endcase
    end
  end

  assign bus.rData = w_rdata;
  assign gpo       = r_gpo;
  assign timerIrq  = w_irq;

  // Address/data bits not consumed by every configuration
  assign w_unused = ^{bus.dataAddr[27:4], bus.dataAddr[1:0], w_reg_wr};

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-side memory controller directly downstream of the RV32I core. It takes the core's store-enable, data address and write data, and returns load data on `rData` in the same cycle. It decodes the address into a word-addressed data RAM and a small memory-mapped register block: a general-purpose output register and an optional down-counting timer with an interrupt flag.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: RAM depth in 32-bit words; power of two, minimum 4.
- `GPO_W`, 8: width of the general-purpose output register, 1..32.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `dataWe`, input, 1: store enable from the core.
- `dataAddr`, input, 32: byte address from the core; bits [1:0] ignored (word access only).
- `datawData`, input, 32: store data from the core.
- `rData`, output, 32: load data to the core; combinational from `dataAddr`.
- `gpo`, output, GPO_W: general-purpose output register contents.
- `timerIrq`, output, 1: level interrupt, equal to the timer pending bit.

## Operation
- Address decode uses `dataAddr[31:28]`:
  - 0x0: RAM. Index is `dataAddr[$clog2(DEPTH_WORDS)+1:2]`; upper bits are ignored, so the RAM aliases across the window.
  - 0x1: register block, decoded on `dataAddr[3:2]`; bits [27:4] are ignored.
  - Any other value: unmapped. Reads return 32'h0; writes have no effect.
- RAM: no reset. Writes are synchronous, one word per `dataWe` cycle. Reads are asynchronous.
- Register block:
  - 0x1000_0000 GPO, RW. Only the low GPO_W bits are stored; upper bits read 0. Reset value 0.
  - 0x1000_0004 TCTRL, RW. bit0 EN, bit1 RELOAD, bit2 PEND. PEND is write-1-to-clear; writing 0 to PEND has no effect. Other bits read 0. Reset value 0.
  - 0x1000_0008 TLOAD, RW, 32 bits. Reset value 0. A write also copies the written value into COUNT.
  - 0x1000_000C TCOUNT, RO. Writes are ignored. Reset value 0.
- Timer, evaluated every cycle while EN=1:
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0 (expiry): PEND is set. If RELOAD=1, COUNT <= TLOAD. If RELOAD=0, EN is cleared and COUNT stays 0.
- Simultaneous events, resolved in the same cycle:
  - Expiry and a write-1 to PEND: the set wins, so PEND=1.
  - Expiry and a TCTRL write: EN and RELOAD take the written values; PEND follows the rule above.
  - Expiry or decrement and a TLOAD write: the written value wins for COUNT.
  - TLOAD=0 with RELOAD=1 and EN=1: expiry occurs every cycle and PEND stays set.
- Reset mid-operation forces GPO, TCTRL, TLOAD and COUNT to 0 immediately, so `gpo`=0 and `timerIrq`=0. RAM contents are preserved.

## Timing
- Load latency is 0 cycles: `rData` is a combinational function of `dataAddr` and the current state.
- A read of the address being written in the same cycle returns the old value. The new value is visible from the next cycle.
- Register writes are visible on `gpo`, `timerIrq` and readback one cycle after the `dataWe` edge.
- Timer latency: a TLOAD write of N at edge k, with EN=1, gives COUNT=N after edge k, COUNT=0 after edge k+N, and PEND=1 (`timerIrq` high) after edge k+N+1.
- `timerIrq` is registered and glitch-free.

## Configuration
- `DATA_MEM_TIMER_EN` defined: the timer registers, counter logic and `timerIrq` are implemented as described above.
- `DATA_MEM_TIMER_EN` undefined: TCTRL, TLOAD and TCOUNT read 32'h0 and ignore writes, `timerIrq` is tied to 0, and no counter logic is present. RAM and GPO behaviour are unchanged.

## Structure
- Package `data_mem_pkg` holds:
  - region constants: REGION_RAM=4'h0, REGION_REG=4'h1;
  - register offsets: GPO=2'd0, TCTRL=2'd1, TLOAD=2'd2, TCOUNT=2'd3;
  - TCTRL bit indices: EN=0, RELOAD=1, PEND=2.
- One sub-module, `timer_unit`, holds the COUNT, TLOAD and TCTRL state, the expiry logic and the write-port decode inputs. It is instantiated only under `DATA_MEM_TIMER_EN`.

## Test plan
- RAM round trip: store 32'hCAFE_F00D to 0x0000_0010, then load 0x0000_0010 -> 32'hCAFE_F00D. Load 0x0000_0410 with DEPTH_WORDS=256 -> same value (aliasing).
- Read-during-write: RAM word holds 32'h1; store 32'h2 to the same address -> `rData`=32'h1 during the write cycle and 32'h2 the next cycle.
- GPO and unmapped space: store 32'hFFFF_FFA5 to 0x1000_0000 -> `gpo`=8'hA5 next cycle and readback 32'h0000_00A5. Store to 0x2000_0000, then load it -> 32'h0 and no state change.
- One-shot timer: write TCTRL=1, then TLOAD=3 -> COUNT reads 3,2,1,0; `timerIrq` rises one cycle after COUNT=0; EN reads 0. Writing TCTRL=32'h4 clears `timerIrq` next cycle.
- Auto-reload and collision: TLOAD=2 with TCTRL=3 -> PEND set every 3 cycles. A write-1 to PEND in the expiry cycle leaves `timerIrq`=1. Asserting `reset` mid-count -> `gpo`=0, `timerIrq`=0 and COUNT=0 immediately.
- Macro off: build without `DATA_MEM_TIMER_EN`; write TCTRL=1 and TLOAD=5 -> all timer reads return 32'h0 and `timerIrq` stays 0.
